// File: rtl/switch_op_decoder.sv
// rtl/switch_op_decoder.sv - debounced one-hot mode switch to operation code decoder
module switch_op_decoder #(
    parameter  int N_SW            = 5,
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int OP_W            = $clog2(N_SW + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw,
    input  logic            lock,
    output logic [OP_W-1:0] op,
    output logic            op_valid,
    output logic            op_change,
    output logic            conflict
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_INVALID,
        ST_VALID,
        ST_LOCKED
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [N_SW-1:0] sync1;
    logic [N_SW-1:0] synced;
    logic [N_SW-1:0] deb;
    logic [OP_W-1:0] dec;
    logic [OP_W-1:0] op_next;
    logic            multi;

    // Two-flop synchronizer on every raw switch line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            synced <= '0;
        end else begin
            sync1  <= sw;
            synced <= sync1;
        end
    end

    for (genvar k = 0; k < N_SW; k++) begin : g_deb
        logic [CNT_W-1:0] cnt;
        logic             deb_q;

        // Per-switch debounce: level accepted after DEBOUNCE_CYCLES consecutive differing samples
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                deb_q <= 1'b0;
            end else if (synced[k] == deb_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                deb_q <= ~deb_q;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign deb[k] = deb_q;
    end

    // Priority-slot decode: a single high switch k maps to code N_SW-k, anything else to 0
    always_comb begin
        dec   = '0;
        multi = (deb & (deb - N_SW'(1))) != '0;
        for (int k = 0; k < N_SW; k++) begin
            if (deb[k]) begin
                dec = OP_W'(N_SW - k);
            end
        end
        if (multi) begin
            dec = '0;
        end
    end

    // Next-state and next-op selection; op only moves outside the LOCKED state
    always_comb begin
        state_next = state;
        op_next    = op;
        unique case (state)
            ST_INVALID: begin
                if (lock) begin
                    state_next = ST_LOCKED;
                end else if (dec != '0) begin
                    state_next = ST_VALID;
                    op_next    = dec;
                end
            end
            ST_VALID: begin
                if (lock) begin
                    state_next = ST_LOCKED;
                end else if (dec == '0) begin
                    state_next = ST_INVALID;
                    op_next    = '0;
                end else begin
                    op_next = dec;
                end
            end
            ST_LOCKED: begin
                if (!lock) begin
                    state_next = (dec != '0) ? ST_VALID : ST_INVALID;
                    op_next    = dec;
                end
            end
            default: begin
                state_next = ST_INVALID;
                op_next    = '0;
            end
        endcase
    end

    // State and registered outputs; op_change marks the cycle op takes a new value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INVALID;
            op        <= '0;
            op_valid  <= 1'b0;
            op_change <= 1'b0;
            conflict  <= 1'b0;
        end else begin
            state     <= state_next;
            op        <= op_next;
            op_valid  <= op_next != '0;
            op_change <= op_next != op;
            conflict  <= multi;
        end
    end

endmodule

// File: tb/tb_switch_op_decoder.sv
// tb/tb_switch_op_decoder.sv - directed self-checking bench for switch_op_decoder
`timescale 1ns/100ps
module tb_switch_op_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] sw_a = '0;
    logic       lock_a = 1'b0;
    logic [2:0] op_a;
    logic       op_valid_a;
    logic       op_change_a;
    logic       conflict_a;
    logic [7:0] sw_b = '0;
    logic       lock_b = 1'b0;
    logic [3:0] op_b;
    logic       op_valid_b;
    logic       op_change_b;
    logic       conflict_b;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;
    int base;

    switch_op_decoder #(.N_SW(5), .DEBOUNCE_CYCLES(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .sw(sw_a), .lock(lock_a),
        .op(op_a), .op_valid(op_valid_a), .op_change(op_change_a), .conflict(conflict_a)
    );

    switch_op_decoder #(.N_SW(8), .DEBOUNCE_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .sw(sw_b), .lock(lock_b),
        .op(op_b), .op_valid(op_valid_b), .op_change(op_change_b), .conflict(conflict_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (op_change_a) pulses++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(2);
        check("rst_op", int'(op_a), 0);
        check("rst_valid", int'(op_valid_a), 0);
        check("rst_change", int'(op_change_a), 0);
        check("rst_conflict", int'(conflict_a), 0);
        rst_n = 1'b1;
        tick(1);

        // single switch from reset: 19-edge latency
        sw_a = 5'b00001;
        base = pulses;
        tick(18);
        check("lat19_before", int'(op_a), 0);
        tick(1);
        check("lat19_op", int'(op_a), 5);
        check("lat19_valid", int'(op_valid_a), 1);
        check("lat19_change", int'(op_change_a), 1);
        tick(1);
        check("lat19_change_drop", int'(op_change_a), 0);
        check("lat19_pulses", pulses - base, 1);

        // release, then bounce on bit 4
        sw_a = 5'b00000;
        tick(25);
        check("release_op", int'(op_a), 0);
        base = pulses;
        sw_a = 5'b10000;
        tick(10);
        sw_a = 5'b00000;
        tick(2);
        check("bounce_mid_op", int'(op_a), 0);
        sw_a = 5'b10000;
        tick(18);
        check("bounce_before", int'(op_a), 0);
        check("bounce_no_pulse", pulses - base, 0);
        tick(1);
        check("bounce_op", int'(op_a), 1);
        check("bounce_pulses", pulses - base, 1);

        // simultaneous fall of bit 4 and rise of bit 2: direct 1 -> 3
        base = pulses;
        sw_a = 5'b00100;
        tick(18);
        check("swap_before", int'(op_a), 1);
        tick(1);
        check("swap_op", int'(op_a), 3);
        check("swap_valid", int'(op_valid_a), 1);
        tick(1);
        check("swap_pulses", pulses - base, 1);

        // second switch joins: conflict
        base = pulses;
        sw_a = 5'b00110;
        tick(18);
        check("conf_before", int'(conflict_a), 0);
        tick(1);
        check("conf_op", int'(op_a), 0);
        check("conf_valid", int'(op_valid_a), 0);
        check("conf_flag", int'(conflict_a), 1);
        tick(1);
        check("conf_pulses", pulses - base, 1);

        // back to op=3, then lock while the switches move
        sw_a = 5'b00100;
        tick(20);
        check("relock_op", int'(op_a), 3);
        check("relock_conflict", int'(conflict_a), 0);
        base = pulses;
        lock_a = 1'b1;
        sw_a = 5'b01000;
        tick(40);
        check("locked_op", int'(op_a), 3);
        check("locked_valid", int'(op_valid_a), 1);
        check("locked_pulses", pulses - base, 0);
        lock_a = 1'b0;
        tick(1);
        check("unlock_op", int'(op_a), 2);
        check("unlock_change", int'(op_change_a), 1);
        tick(1);
        check("unlock_pulses", pulses - base, 1);
        base = pulses;
        lock_a = 1'b1;
        tick(5);
        lock_a = 1'b0;
        tick(1);
        check("unlock2_op", int'(op_a), 2);
        check("unlock2_change", int'(op_change_a), 0);
        tick(2);
        check("unlock2_pulses", pulses - base, 0);

        // short asynchronous reset mid-debounce
        sw_a = 5'b00001;
        tick(8);
        #2;
        rst_n = 1'b0;
        #0.5;
        check("async_op", int'(op_a), 0);
        check("async_valid", int'(op_valid_a), 0);
        check("async_change", int'(op_change_a), 0);
        check("async_conflict", int'(conflict_a), 0);
        #0.5;
        rst_n = 1'b1;
        base = pulses;
        tick(1);
        tick(17);
        check("post_rst_before", int'(op_a), 0);
        check("post_rst_no_pulse", pulses - base, 0);
        tick(1);
        check("post_rst_op", int'(op_a), 5);
        tick(1);
        check("post_rst_pulses", pulses - base, 1);

        // 8-switch instance, single-cycle debounce: 4-edge latency per pattern
        for (int i = 0; i < 8; i++) begin
            sw_b = 8'h80 >> i;
            tick(3);
            check($sformatf("b_hold_%0d", i), int'(op_b), i);
            tick(1);
            check($sformatf("b_op_%0d", i), int'(op_b), i + 1);
            check($sformatf("b_valid_%0d", i), int'(op_valid_b), 1);
            check($sformatf("b_change_%0d", i), int'(op_change_b), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/switch_op_decoder.md
SWITCH_OP_DECODER -- requirements
Module: switch_op_decoder

Interface
REQ-001 Parameter N_SW, default 5, number of mode switches (2..15).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles needed to accept a switch level (>=1).
REQ-003 Derived OP_W = $clog2(N_SW+1); not overridable.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 sw  input  N_SW  raw asynchronous switch levels, bit N_SW-1 = highest-priority mode slot.
REQ-007 lock  input  1  synchronous; high freezes op/op_valid (e.g. during a running operation).
REQ-008 op  output  OP_W  registered operation code; 0 = invalid/none.
REQ-009 op_valid  output  1  registered; high when op != 0.
REQ-010 op_change  output  1  one-cycle pulse on each update of op.
REQ-011 conflict  output  1  registered; high while more than one debounced switch is high.

Function
REQ-012 Each sw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each bit SHALL own a debounce counter of width $clog2(DEBOUNCE_CYCLES+1) and a debounced level deb[k].
REQ-014 Counter SHALL clear to 0 on any cycle where synced[k] == deb[k]; otherwise it SHALL increment.
REQ-015 deb[k] SHALL toggle, and its counter clear, on the edge where the counter equals DEBOUNCE_CYCLES-1 and synced[k] != deb[k].
REQ-016 Decode: exactly one deb[k] high -> code N_SW-k (bit N_SW-1 -> 1, bit 0 -> N_SW); zero or multiple high -> 0.
REQ-017 FSM states: INVALID (op=0), VALID (op!=0), LOCKED (op held).
REQ-018 INVALID -> VALID when lock=0 and decode!=0; VALID -> INVALID when lock=0 and decode==0; VALID -> VALID with new code when decode changes to another nonzero code.
REQ-019 INVALID or VALID -> LOCKED when lock=1; op, op_valid unchanged while LOCKED; op_change SHALL stay 0.
REQ-020 LOCKED -> INVALID/VALID on the first cycle lock=0, loading the current decode; op_change SHALL pulse only if the loaded code differs from the held op.
REQ-021 op_change SHALL be asserted in the same cycle op shows its new value, never when op is unchanged.
REQ-022 conflict SHALL track debounced state irrespective of lock, updated one cycle after deb.
REQ-023 Latency: a clean sw edge held steady SHALL reach op exactly DEBOUNCE_CYCLES+3 clock edges later (2 sync + DEBOUNCE_CYCLES debounce + 1 output register).
REQ-024 A bounce (return to deb level) before the counter completes SHALL restart the full DEBOUNCE_CYCLES window.
REQ-025 Simultaneous acceptance of one switch falling and another rising SHALL produce a direct VALID->VALID transition with a single op_change pulse.

Reset
REQ-026 rst_n low SHALL asynchronously clear synchronizers, counters, deb, op=0, op_valid=0, op_change=0, conflict=0, FSM=INVALID.
REQ-027 After release, switches already high at reset SHALL be accepted via normal debounce (no reset-time sampling shortcut).
REQ-028 Reset asserted mid-debounce or while LOCKED SHALL abandon all progress; no op_change pulse on reset entry or exit.

Verification
REQ-029 N_SW=5, D=16: sw=5'b00001 from reset -> op=5, op_valid=1, one op_change exactly 19 edges after the sw change.
REQ-030 sw bit 4 toggles high for 10 cycles, low 2, high 20 -> op stays 0 until 16 stable cycles after last rise, then op=1.
REQ-031 sw 5'b00100 accepted, then 5'b00110 -> op=0, op_valid=0, conflict=1, one op_change pulse.
REQ-032 op=3, lock=1, sw changed to 5'b01000 for 40 cycles -> op stays 3, no pulse; lock=0 -> op=2 next edge with one pulse; repeat with sw unchanged -> no pulse.
REQ-033 rst_n pulsed low for 1 ns mid-debounce (not clock-aligned) -> all outputs 0 immediately; acceptance resumes full 19-edge latency after release.
REQ-034 N_SW=8, D=1: each single-hot pattern 8'h80..8'h01 in turn -> op=1..8, 4-edge latency each.
